// File: rtl/bcd_digit_scanner_if.sv
// Display-side bundle for the BCD digit scanner: load/blanking controls in,
// multiplexed BCD digit, blanking, digit select and status out.
interface bcd_digit_scanner_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                  load;
    logic [4*N_DIGITS-1:0] digits_in;
    logic                  blank_lz;
    logic [3:0]            bcd_out;
    logic                  blank_out;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  pending;
    logic                  err;

    modport master (
        output load,
        output digits_in,
        output blank_lz,
        input  bcd_out,
        input  blank_out,
        input  digit_en,
        input  pending,
        input  err
    );

    modport slave (
        input  load,
        input  digits_in,
        input  blank_lz,
        output bcd_out,
        output blank_out,
        output digit_en,
        output pending,
        output err
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexes an N-digit packed BCD value onto one shared 7-segment decoder,
// with frame-aligned double buffering, leading-zero blanking and invalid-digit flagging.
module bcd_digit_scanner #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 1000
) (
    input logic                clk,
    input logic                rst_n,
    bcd_digit_scanner_if.slave bus
);
    localparam int unsigned PS_W   = $clog2(PRESCALE);
    localparam int unsigned IDX_W  = $clog2(N_DIGITS);
    localparam int unsigned DATA_W = 4 * N_DIGITS;

    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] EN_RESET = {{(N_DIGITS - 1){1'b0}}, 1'b1};

    logic [PS_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   active_q, active_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                err_q, err_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                blank_q, blank_d;
    logic [N_DIGITS-1:0] en_q, en_d;

    logic                tick;
    logic                boundary;
    logic                commit;
    logic [3:0]          cur_digit;
    logic [N_DIGITS-1:0] lz;
    logic                lz_blank;
    logic                invalid;

    // Prescaler, digit index and double-buffer control
    always_comb begin
        tick     = (count_q == PS_LAST);
        boundary = tick && (idx_q == IDX_LAST);
        commit   = boundary && pending_q;

        count_d = tick ? '0 : count_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load on the boundary cycle lands in shadow after the commit has
        // already taken the old shadow, so pending stays set for the next frame.
        active_d  = commit ? shadow_q : active_q;
        shadow_d  = bus.load ? bus.digits_in : shadow_q;
        pending_d = bus.load | (pending_q & ~commit);
    end

    // Leading-zero map: lz[k] is set when digit k and all above it are zero
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz       = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (active_d[4*k +: 4] == 4'd0);
            lz[k]    = all_zero;
        end
    end

    // Outputs are precomputed from next-state index/value so they move with the index
    always_comb begin
        cur_digit = active_d[{idx_d, 2'b00} +: 4];
        invalid   = (cur_digit > 4'd9);
        lz_blank  = bus.blank_lz && (idx_d != '0) && lz[idx_d];

        blank_d = invalid | lz_blank;
        bcd_d   = blank_d ? 4'd0 : cur_digit;
        err_d   = err_q | invalid;

        en_d = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            en_d[k] = (idx_d == IDX_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            bcd_q     <= 4'd0;
            blank_q   <= 1'b0;
            en_q      <= EN_RESET;
        end else begin
            count_q   <= count_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            en_q      <= en_d;
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.blank_out = blank_q;
    assign bus.digit_en  = en_q;
    assign bus.pending   = pending_q;
    assign bus.err       = err_q;
endmodule

// File: doc/bcd_digit_scanner.md
Name: bcd_digit_scanner

Overview:
- Upstream feeder for the BCD-to-7-segment decoder.
- Holds an N-digit packed BCD value and time-multiplexes it onto one 4-bit BCD bus (w,x,y,z order) plus a one-hot digit-enable, so one shared decoder drives a multi-digit display.
- Double-buffers new values and commits them only at frame boundaries, so no frame ever shows a mix of old and new digits.
- Provides optional leading-zero blanking and invalid-digit flagging.

Parameters:
- N_DIGITS, 4, number of display digits (>=2). Digit 0 is least significant.
- PRESCALE, 1000, clock cycles each digit is displayed (>=2).
- PS_W, $clog2(PRESCALE), prescale counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; capture digits_in into the shadow register.
- digits_in  in  4*N_DIGITS  packed BCD. Digit k is bits [4k+3:4k], with bit 4k+3 = w (MSB).
- blank_lz  in  1  1 = enable leading-zero blanking.
- bcd_out  out  4  BCD code to the decoder; [3]=w, [2]=x, [1]=y, [0]=z.
- blank_out  out  1  1 = current digit must be dark.
- digit_en  out  N_DIGITS  one-hot, active-high select of the current digit.
- pending  out  1  shadow loaded but not yet committed.
- err  out  1  sticky; a committed digit was >9.

Behaviour:
- Reset: clk and rst_n are as decided: one clock, asynchronous active-low reset. Asserting rst_n=0 at any time, including mid-frame, immediately sets:
  - prescale count=0, digit index=0
  - active and shadow registers = all zero
  - pending=0, err=0
  - bcd_out=0, blank_out=0, digit_en=1 (digit 0 selected)
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick = (count==PRESCALE-1).
  - On tick, index advances index+1, wrapping N_DIGITS-1 -> 0.
  - After reset release, each digit is shown for exactly PRESCALE cycles.
- Frame boundary = tick while index==N_DIGITS-1.
  - At that edge, if pending=1: active <= shadow and pending <= 0.
  - The committed value is therefore first displayed at digit 0 of the new frame.
- Load:
  - On load=1: shadow <= digits_in, pending <= 1.
  - Multiple loads before a boundary: the last one wins.
  - load in the same cycle as a boundary: the commit uses the pre-edge shadow (only if pending was already 1). The new data lands in shadow, pending=1 after the edge, and it commits at the following boundary.
- Outputs are registered. They are computed from the next-state index and active value, so digit_en, bcd_out and blank_out change on the same edge as the index. There is no extra latency.
  - digit_en is always exactly one-hot.
- Per-digit display (digit d = active[4*index+3:4*index]):
  - d>9: blank_out=1, bcd_out=0, and err sets (sticky until reset) on the edge that makes that digit current.
  - d<=9 and not blanked: bcd_out=d, blank_out=0.
- Leading-zero blanking (blank_lz=1):
  - Digit k>0 is blanked when it and every more significant digit are 0.
  - Invalid digits count as nonzero.
  - Digit 0 is never blanked.
  - blank_lz is sampled live (not buffered).
- Width rule: digits_in width must equal 4*N_DIGITS. No arithmetic is performed on digit values.

Test Plan (N_DIGITS=4, PRESCALE=4):
- Reset then run 20 cycles:
  - outputs show digit_en=0001,0010,0100,1000,0001, 4 cycles each
  - bcd_out=0, blank_out=0, pending=0, err=0 throughout
- load digits_in=16'h1234 during index 1:
  - pending=1 until the next boundary
  - then bcd_out=4,3,2,1 for digit_en=0001..1000
  - pending=0 after the commit
- Commit 16'h0040 with blank_lz=1:
  - digit 0 shows 0 with blank_out=0
  - digit 1 shows 4
  - digits 2 and 3 have blank_out=1
  - with blank_lz=0, all four digits are unblanked
- Commit 16'h00A5:
  - digit 1 shows blank_out=1, bcd_out=0
  - err=1 from that edge and stays 1 across later frames and new loads until rst_n=0
- load 16'h1111 then 16'h2222 before a boundary, plus a third load 16'h3333 on the boundary cycle:
  - the next frame shows 2222
  - pending stays 1
  - the following frame shows 3333
- Pulse rst_n low mid-digit at index 2 with pending=1:
  - immediately digit_en=0001, bcd_out=0, pending=0
  - after release, the previously loaded value is never displayed
